// File: rtl/requantize_control_if.sv
// Calculator-side interface of the requantize controller. The controller
// (master) publishes one line's parameters and a start strobe. The
// requantize calculator (slave) reports whether it can accept work and
// whether it is still busy with a line.
//
// Handshake: the master raises calc_start for exactly one cycle, and only
// after it has sampled calc_ready=1 and calc_active=0 on a clock edge.
// calc_start is registered, so it never depends combinationally on calc_ready.
// calc_index, calc_cb, calc_window, calc_mode and sel_subblock_gain are valid
// from the calc_start cycle. They hold until the master observes calc_active=0
// after the start, which marks that line as complete.
interface requantize_control_if;
  logic       calc_start;
  logic       calc_ready;
  logic       calc_active;
  logic [9:0] calc_index;
  logic [4:0] calc_cb;
  logic [1:0] calc_window;
  logic       calc_mode;
  logic [2:0] sel_subblock_gain;

  modport master (
    output calc_start, calc_index, calc_cb, calc_window, calc_mode, sel_subblock_gain,
    input  calc_ready, calc_active
  );

  modport slave (
    input  calc_start, calc_index, calc_cb, calc_window, calc_mode, sel_subblock_gain,
    output calc_ready, calc_active
  );
endinterface

// File: rtl/requantize_control.sv
// Sequences the 576 lines of one granule through the requantize calculator.
// It supplies each line's scalefactor band, short window, block mode and the
// selected subblock gain. The band tables are fixed for 44.1 kHz.
module requantize_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_granule,
  input  logic       window_switching_flag,
  input  logic       mixed_block_flag,
  input  logic [1:0] block_type,
  input  logic [2:0] subblock_gain0,
  input  logic [2:0] subblock_gain1,
  input  logic [2:0] subblock_gain2,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg,
  requantize_control_if.master calc
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_STARTED    = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t state, nxt;

  logic [9:0] index;
  logic [4:0] cb;
  logic [1:0] win;
  logic [5:0] pos;
  logic       mode;
  logic       mixed_lat;
  logic [2:0] gain0_lat, gain1_lat, gain2_lat;
  logic [2:0] sel_gain;
  logic       busy_q, done_q, start_q;

  logic short_blk, accept, last_line, advance;

  // First line of long band k; entry 22 is the end of the spectrum.
  function automatic logic [9:0] long_start(input logic [4:0] k);
    case (k)
      5'd0:    long_start = 10'd0;
      5'd1:    long_start = 10'd4;
      5'd2:    long_start = 10'd8;
      5'd3:    long_start = 10'd12;
      5'd4:    long_start = 10'd16;
      5'd5:    long_start = 10'd20;
      5'd6:    long_start = 10'd24;
      5'd7:    long_start = 10'd30;
      5'd8:    long_start = 10'd36;
      5'd9:    long_start = 10'd44;
      5'd10:   long_start = 10'd52;
      5'd11:   long_start = 10'd62;
      5'd12:   long_start = 10'd74;
      5'd13:   long_start = 10'd90;
      5'd14:   long_start = 10'd110;
      5'd15:   long_start = 10'd134;
      5'd16:   long_start = 10'd162;
      5'd17:   long_start = 10'd196;
      5'd18:   long_start = 10'd238;
      5'd19:   long_start = 10'd288;
      5'd20:   long_start = 10'd342;
      5'd21:   long_start = 10'd418;
      default: long_start = 10'd576;
    endcase
  endfunction

  // Lines per window in short band k.
  function automatic logic [5:0] short_width(input logic [4:0] k);
    case (k)
      5'd0, 5'd1, 5'd2, 5'd3: short_width = 6'd4;
      5'd4:    short_width = 6'd6;
      5'd5:    short_width = 6'd8;
      5'd6:    short_width = 6'd10;
      5'd7:    short_width = 6'd12;
      5'd8:    short_width = 6'd14;
      5'd9:    short_width = 6'd18;
      5'd10:   short_width = 6'd22;
      5'd11:   short_width = 6'd30;
      default: short_width = 6'd56;
    endcase
  endfunction

  assign short_blk = window_switching_flag & (block_type == 2'd2);
  assign accept    = (state == S_IDLE) & start_granule;
  assign last_line = (index == 10'd575);
  assign advance   = (state == S_WAIT_DONE) & ~calc.calc_active & ~last_line;

  // State register; reset wins over any pending start request.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic for the per-line start/complete handshake.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:       if (start_granule) nxt = S_WAIT_READY;
      S_WAIT_READY: if (calc.calc_ready && !calc.calc_active) nxt = S_STARTED;
      S_STARTED:    nxt = S_WAIT_DONE;
      S_WAIT_DONE:  if (!calc.calc_active) nxt = last_line ? S_DONE : S_WAIT_READY;
      S_DONE:       nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  // Registered status and strobe outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      busy_q  <= (nxt != S_IDLE);
      done_q  <= (nxt == S_DONE);
      start_q <= (nxt == S_STARTED);
    end
  end

  // Line, band, window and position counters; they move only on the advance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      cb        <= '0;
      win       <= '0;
      pos       <= '0;
      mode      <= 1'b0;
      mixed_lat <= 1'b0;
      gain0_lat <= '0;
      gain1_lat <= '0;
      gain2_lat <= '0;
      sel_gain  <= '0;
    end else if (accept) begin
      index     <= '0;
      cb        <= '0;
      win       <= '0;
      pos       <= '0;
      mixed_lat <= short_blk & mixed_block_flag;
      mode      <= ~(short_blk & ~mixed_block_flag);
      gain0_lat <= subblock_gain0;
      gain1_lat <= subblock_gain1;
      gain2_lat <= subblock_gain2;
      sel_gain  <= (short_blk & ~mixed_block_flag) ? subblock_gain0 : 3'd0;
    end else if (advance) begin
      index <= index + 10'd1;
      if (mode) begin
        if (mixed_lat && index == 10'd35) begin
          // Mixed blocks leave the long region straight into short band 3.
          mode     <= 1'b0;
          cb       <= 5'd3;
          win      <= 2'd0;
          pos      <= 6'd0;
          sel_gain <= gain0_lat;
        end else if (cb != 5'd21 && (index + 10'd1) == long_start(cb + 5'd1)) begin
          cb <= cb + 5'd1;
        end
      end else if (pos == short_width(cb) - 6'd1) begin
        pos <= 6'd0;
        if (win == 2'd2) begin
          win      <= 2'd0;
          cb       <= cb + 5'd1;
          sel_gain <= gain0_lat;
        end else begin
          win      <= win + 2'd1;
          sel_gain <= (win == 2'd0) ? gain1_lat : gain2_lat;
        end
      end else begin
        pos <= pos + 6'd1;
      end
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign state_dbg              = state;
  assign calc.calc_start        = start_q;
  assign calc.calc_index        = index;
  assign calc.calc_cb           = cb;
  assign calc.calc_window       = win;
  assign calc.calc_mode         = mode;
  assign calc.sel_subblock_gain = sel_gain;

endmodule

// File: tb/tb_requantize_control.sv
// Bench for requantize_control. It acts as the requantize calculator, drives
// whole granules, and compares every line's parameters with a band-table
// reference model.
module tb_requantize_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_granule;
  logic       wsf, mbf;
  logic [1:0] bt;
  logic [2:0] g0, g1, g2;
  logic       busy, done;
  logic [2:0] state_dbg;

  requantize_control_if calc_if ();

  requantize_control dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_granule         (start_granule),
    .window_switching_flag (wsf),
    .mixed_block_flag      (mbf),
    .block_type            (bt),
    .subblock_gain0        (g0),
    .subblock_gain1        (g1),
    .subblock_gain2        (g2),
    .busy                  (busy),
    .done                  (done),
    .state_dbg             (state_dbg),
    .calc                  (calc_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int long_start[23];
  int short_w[13];

  // Event monitor: counts strobes and pulses and flags back-to-back starts.
  int   start_cnt = 0;
  int   done_cnt  = 0;
  int   dbl_cnt   = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (calc_if.calc_start === 1'b1) start_cnt++;
    if (calc_if.calc_start === 1'b1 && prev_start === 1'b1) dbl_cnt++;
    if (done === 1'b1) done_cnt++;
    prev_start = calc_if.calc_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: derive band, window, mode and gain from the band tables.
  task automatic model(input int idx, input bit sb, input bit mx, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [2:0] a2,
                       output int cb, output int win, output int mode, output int gain);
    int off;
    if (!sb || (mx && idx < 36)) begin
      mode = 1; win = 0; gain = 0; cb = 0;
      for (int k = 0; k < 22; k++) if (long_start[k] <= idx) cb = k;
    end else begin
      mode = 0;
      off  = mx ? idx - 36 : idx;
      cb   = mx ? 3 : 0;
      while (off >= 3 * short_w[cb]) begin
        off -= 3 * short_w[cb];
        cb++;
      end
      win  = off / short_w[cb];
      gain = (win == 0) ? a0 : (win == 1) ? a1 : a2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},  calc_if.calc_start, 0);
    check({tag, "_index"},  calc_if.calc_index, 0);
    check({tag, "_cb"},     calc_if.calc_cb, 0);
    check({tag, "_window"}, calc_if.calc_window, 0);
    check({tag, "_mode"},   calc_if.calc_mode, 0);
    check({tag, "_gain"},   calc_if.sel_subblock_gain, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_state"},  state_dbg, 0);
  endtask

  // Driver: one calculator transaction for line idx. ok=0 means the granule stopped.
  task automatic do_line(input int idx, input bit sb, input bit mx, input int rd, input int ac,
                         input bit pulse_start, input bit abort, output bit ok);
    int   e_cb, e_win, e_mode, e_gain, d0;
    bit   found, stable, quiet;
    logic [21:0] snap;
    logic        sw, sm;
    logic [1:0]  sbt;
    ok = 1'b0;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      check("no_start_before_ready", calc_if.calc_start, 0);
    end
    calc_if.calc_ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (calc_if.calc_start === 1'b1) found = 1'b1;
    end
    check("start_seen", found, 1);
    if (!found) return;
    model(idx, sb, mx, g0, g1, g2, e_cb, e_win, e_mode, e_gain);
    check("index",  calc_if.calc_index, idx);
    check("cb",     calc_if.calc_cb, e_cb);
    check("window", calc_if.calc_window, e_win);
    check("mode",   calc_if.calc_mode, e_mode);
    check("gain",   calc_if.sel_subblock_gain, e_gain);
    if (abort) begin
      rst = 1'b1;
      start_granule = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start_granule = 1'b0;
      calc_if.calc_ready = 1'b0;
      check_all_zero("after_reset");
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      check("no_done_after_reset", done_cnt - d0, 0);
      check("idle_after_reset", busy, 0);
      return;
    end
    calc_if.calc_active = 1'b1;
    calc_if.calc_ready  = 1'b0;
    snap   = {calc_if.calc_index, calc_if.calc_cb, calc_if.calc_window,
              calc_if.calc_mode, calc_if.sel_subblock_gain};
    stable = 1'b1;
    quiet  = 1'b1;
    sw = wsf; sm = mbf; sbt = bt;
    for (int c = 0; c < ac; c++) begin
      @(negedge clk);
      if (pulse_start && c == 1) begin
        start_granule = 1'b1; wsf = ~sw; mbf = ~sm; bt = ~sbt;
      end
      if (pulse_start && c == 2) begin
        start_granule = 1'b0; wsf = sw; mbf = sm; bt = sbt;
      end
      if (snap !== {calc_if.calc_index, calc_if.calc_cb, calc_if.calc_window,
                    calc_if.calc_mode, calc_if.sel_subblock_gain}) stable = 1'b0;
      if (calc_if.calc_start !== 1'b0) quiet = 1'b0;
    end
    check("params_stable", stable, 1);
    check("no_start_while_active", quiet, 1);
    calc_if.calc_active = 1'b0;
    ok = 1'b1;
  endtask

  // Driver: one full granule, with optional handshake stall, stray start and abort lines.
  task automatic run_granule(input bit w, input bit m, input logic [1:0] b,
                             input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                             input int act_fixed, input int hs_line, input int pulse_line,
                             input int stop_line);
    int s0, d0, x0, rd, ac;
    bit sb, mx, ok, seen;
    wsf = w; mbf = m; bt = b; g0 = a0; g1 = a1; g2 = a2;
    sb = w && (b == 2'd2);
    mx = sb && m;
    s0 = start_cnt; d0 = done_cnt; x0 = dbl_cnt;
    calc_if.calc_ready  = 1'b0;
    calc_if.calc_active = 1'b0;
    start_granule = 1'b1;
    @(negedge clk);
    start_granule = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_start_on_accept", calc_if.calc_start, 0);
    for (int idx = 0; idx < 576; idx++) begin
      rd = (idx == hs_line) ? 5 : $urandom_range(0, 1);
      if (idx == hs_line)         ac = 20;
      else if (idx == pulse_line) ac = 6;
      else if (act_fixed > 0)     ac = act_fixed;
      else                        ac = $urandom_range(1, 5);
      do_line(idx, sb, mx, rd, ac, idx == pulse_line, idx == stop_line, ok);
      if (!ok) return;
      if (idx < 575) check("no_early_done", done_cnt - d0, 0);
    end
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_pulse", seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
    check("idle_after_done", state_dbg, 0);
    check("start_count", start_cnt - s0, 576);
    check("done_count", done_cnt - d0, 1);
    check("no_double_start", dbl_cnt - x0, 0);
  endtask

  initial begin
    int ls[23] = '{0, 4, 8, 12, 16, 20, 24, 30, 36, 44, 52, 62, 74, 90, 110, 134, 162,
                   196, 238, 288, 342, 418, 576};
    int sw[13] = '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56};
    long_start = ls;
    short_w    = sw;

    rst = 1'b1; start_granule = 1'b0;
    wsf = 1'b0; mbf = 1'b0; bt = 2'd0; g0 = 3'd0; g1 = 3'd0; g2 = 3'd0;
    calc_if.calc_ready = 1'b0; calc_if.calc_active = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_release", state_dbg, 0);

    // Long block, calculator active four cycles per line.
    run_granule(1'b0, 1'b0, 2'd0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 4, -1, -1, -1);
    // Pure short block, random gains and timing.
    run_granule(1'b1, 1'b0, 2'd2, 3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)),
                3'($urandom_range(1, 7)), 0, -1, -1, -1);
    // Mixed block with gains 1/2/3.
    run_granule(1'b1, 1'b1, 2'd2, 3'd1, 3'd2, 3'd3, 0, -1, -1, -1);
    // Window switching without short blocks: stalled handshake, stray start mid-granule.
    run_granule(1'b1, 1'b1, 2'd1, 3'd5, 3'd6, 3'd7, 0, 37, 200, -1);
    // Short block aborted by reset at line 100, then a fresh long granule from line 0.
    run_granule(1'b1, 1'b0, 2'd2, 3'd4, 3'd5, 3'd6, 0, -1, -1, 100);
    run_granule(1'b0, 1'b1, 2'd2, 3'd2, 3'd3, 3'd4, 0, 5, 300, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
